// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the mult/div sequencer and its requester/unit.
// The master drives requests and unit completion; the slave is the sequencer.
interface muldiv_sequencer_if;
   logic       start;
   logic       op;
   logic       divisor_zero;
   logic       unit_done;
   logic       busy;
   logic       unit_start;
   logic       multOp;
   logic       divOp;
   logic       hilo_write;
   logic       done;
   logic       div0_exc;
   logic       timeout_exc;
   logic [5:0] cycles;

   modport master (
      output start, op, divisor_zero, unit_done,
      input  busy, unit_start, multOp, divOp, hilo_write, done,
             div0_exc, timeout_exc, cycles
   );

   modport slave (
      input  start, op, divisor_zero, unit_done,
      output busy, unit_start, multOp, divOp, hilo_write, done,
             div0_exc, timeout_exc, cycles
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Issue/wait/write-back sequencer for a multicycle mult/div unit with
// divide-by-zero and watchdog exceptions.
//
// state   | meaning
// --------+-----------------------------------------------------
// S_IDLE  | waiting for start; captures op and divide-by-zero cause
// S_ISSUE | one-cycle unit_start pulse to the mult/div unit
// S_WAIT  | counting cycles until unit_done or watchdog terminal count
// S_WRITE | one-cycle HI/LO write enable
// S_DONE  | one-cycle normal completion pulse
// S_EXC   | one-cycle completion pulse plus the captured exception cause
module muldiv_sequencer #(
   parameter logic [5:0] TIMEOUT = 6'd40
) (
   input  logic                i_clk,
   input  logic                i_reset,
   muldiv_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_EXC
   } state_t;

   localparam logic [5:0] LP_TC = TIMEOUT - 6'd1;

   state_t     r_state;
   state_t     w_next;
   logic       r_op;
   logic       r_div0_cause;
   logic [5:0] r_cycles;

   logic       w_busy;
   logic       w_unit_start;
   logic       w_multOp;
   logic       w_divOp;
   logic       w_hilo_write;
   logic       w_done;
   logic       w_div0_exc;
   logic       w_timeout_exc;
   logic       w_div0_req;

   assign w_div0_req = bus.op & bus.divisor_zero;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_busy        = 1'b1;
      w_unit_start  = 1'b0;
      w_multOp      = 1'b0;
      w_divOp       = 1'b0;
      w_hilo_write  = 1'b0;
      w_done        = 1'b0;
      w_div0_exc    = 1'b0;
      w_timeout_exc = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_next = w_div0_req ? S_EXC : S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_unit_start = 1'b1;
            w_multOp     = ~r_op;
            w_divOp      = r_op;
            w_next       = S_WAIT;
         end
         S_WAIT: begin
            w_multOp = ~r_op;
            w_divOp  = r_op;
            // completion wins over the watchdog in the same cycle
            if (bus.unit_done) begin
               w_next = S_WRITE;
            end else if (r_cycles == LP_TC) begin
               w_next = S_EXC;
            end
         end
         S_WRITE: begin
            w_multOp     = ~r_op;
            w_divOp      = r_op;
            w_hilo_write = 1'b1;
            w_next       = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         S_EXC: begin
            w_done        = 1'b1;
            w_div0_exc    = r_div0_cause;
            w_timeout_exc = ~r_div0_cause;
            w_next        = S_IDLE;
         end
         default: begin
            w_busy = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_op         <= 1'b0;
         r_div0_cause <= 1'b0;
         r_cycles     <= 6'd0;
      end else if (r_state == S_IDLE) begin
         if (bus.start) begin
            r_op         <= bus.op;
            r_div0_cause <= w_div0_req;
            // a divide-by-zero never runs the unit, so the last count is kept
            if (!w_div0_req) begin
               r_cycles <= 6'd0;
            end
         end
      end else if (r_state == S_WAIT && r_cycles != 6'd63) begin
         r_cycles <= r_cycles + 6'd1;
      end
   end

   assign bus.busy        = w_busy;
   assign bus.unit_start  = w_unit_start;
   assign bus.multOp      = w_multOp;
   assign bus.divOp       = w_divOp;
   assign bus.hilo_write  = w_hilo_write;
   assign bus.done        = w_done;
   assign bus.div0_exc    = w_div0_exc;
   assign bus.timeout_exc = w_timeout_exc;
   assign bus.cycles      = r_cycles;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; output vector bit order is
// {busy, unit_start, multOp, divOp, hilo_write, done, div0_exc, timeout_exc}.
module tb_muldiv_sequencer;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   muldiv_sequencer_if bus ();

   muldiv_sequencer #(.TIMEOUT(6'd40)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {bus.busy, bus.unit_start, bus.multOp, bus.divOp,
              bus.hilo_write, bus.done, bus.div0_exc, bus.timeout_exc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [7:0] exp_o, input logic [5:0] exp_c);
      chk({tag, ".outs"}, outs(), exp_o);
      chk({tag, ".cycles"}, {2'b00, bus.cycles}, {2'b00, exp_c});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.divisor_zero = 1'b0;
      bus.unit_done = 1'b0;
      tick();
      tick();
      chk_st("reset", 8'b0000_0000, 6'd0);
      rst = 1'b0;
      tick();
      chk_st("idle_after_reset", 8'b0000_0000, 6'd0);

      // multiply, unit_done at cycle 5
      bus.start = 1'b1; bus.op = 1'b0;
      tick();                                  // cycle 1
      bus.start = 1'b0;
      chk_st("mul.issue", 8'b1110_0000, 6'd0);
      tick(); chk_st("mul.wait2", 8'b1010_0000, 6'd0);
      tick(); chk_st("mul.wait3", 8'b1010_0000, 6'd1);
      tick(); chk_st("mul.wait4", 8'b1010_0000, 6'd2);
      tick(); chk_st("mul.wait5", 8'b1010_0000, 6'd3);
      bus.unit_done = 1'b1;
      tick();                                  // cycle 6
      bus.unit_done = 1'b0;
      chk_st("mul.write", 8'b1010_1000, 6'd4);
      tick(); chk_st("mul.done", 8'b1000_0100, 6'd4);
      tick(); chk_st("mul.idle", 8'b0000_0000, 6'd4);

      // divide by zero, then back-to-back multiply with early unit_done
      bus.start = 1'b1; bus.op = 1'b1; bus.divisor_zero = 1'b1;
      tick();
      bus.start = 1'b0; bus.op = 1'b0; bus.divisor_zero = 1'b0;
      chk_st("div0.exc", 8'b1000_0110, 6'd4);
      tick();
      chk_st("div0.idle", 8'b0000_0000, 6'd4);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.unit_done = 1'b1;                    // ignored in ISSUE
      chk_st("b2b.issue", 8'b1110_0000, 6'd0);
      tick(); chk_st("b2b.wait", 8'b1010_0000, 6'd0);
      tick();
      bus.unit_done = 1'b0;
      chk_st("b2b.write", 8'b1010_1000, 6'd1);
      tick(); chk_st("b2b.done", 8'b1000_0100, 6'd1);
      tick(); chk_st("b2b.idle", 8'b0000_0000, 6'd1);

      // divide that never completes: watchdog
      bus.start = 1'b1; bus.op = 1'b1; bus.divisor_zero = 1'b0;
      tick();
      bus.start = 1'b0;
      chk_st("tmo.issue", 8'b1101_0000, 6'd0);
      for (int i = 2; i <= 41; i++) begin
         tick();
         chk_st($sformatf("tmo.wait%0d", i), 8'b1001_0000, 6'(i - 2));
      end
      tick(); chk_st("tmo.exc", 8'b1000_0101, 6'd40);
      tick(); chk_st("tmo.idle", 8'b0000_0000, 6'd40);

      // unit_done on the terminal-count cycle wins
      bus.start = 1'b1; bus.op = 1'b0;
      tick();
      bus.start = 1'b0;
      chk_st("edge.issue", 8'b1110_0000, 6'd0);
      for (int i = 2; i <= 41; i++) tick();
      chk_st("edge.tc", 8'b1010_0000, 6'd39);
      bus.unit_done = 1'b1;
      tick();
      bus.unit_done = 1'b0;
      chk_st("edge.write", 8'b1010_1000, 6'd40);
      tick(); chk_st("edge.done", 8'b1000_0100, 6'd40);
      tick(); chk_st("edge.idle", 8'b0000_0000, 6'd40);

      // start during WAIT with op toggled is ignored
      bus.start = 1'b1; bus.op = 1'b1; bus.divisor_zero = 1'b0;
      tick();
      bus.start = 1'b0;
      chk_st("busy.issue", 8'b1101_0000, 6'd0);
      tick();
      chk_st("busy.wait", 8'b1001_0000, 6'd0);
      bus.start = 1'b1; bus.op = 1'b0; bus.divisor_zero = 1'b1;
      tick();
      bus.start = 1'b0;
      chk_st("busy.held", 8'b1001_0000, 6'd1);
      bus.unit_done = 1'b1;
      tick();
      bus.unit_done = 1'b0;
      chk_st("busy.write", 8'b1001_1000, 6'd2);
      tick(); chk_st("busy.done", 8'b1000_0100, 6'd2);
      tick(); chk_st("busy.idle", 8'b0000_0000, 6'd2);
      tick(); chk_st("busy.noqueue", 8'b0000_0000, 6'd2);
      bus.divisor_zero = 1'b0;

      // reset at WAIT cycle 3 with start and unit_done asserted
      bus.start = 1'b1; bus.op = 1'b0;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick(); tick();
      chk_st("rst.wait3", 8'b1010_0000, 6'd3);
      rst = 1'b1; bus.start = 1'b1; bus.unit_done = 1'b1;
      tick();
      chk_st("rst.abort", 8'b0000_0000, 6'd0);
      rst = 1'b0; bus.start = 1'b0; bus.unit_done = 1'b0;
      tick(); chk_st("rst.quiet1", 8'b0000_0000, 6'd0);
      tick(); chk_st("rst.quiet2", 8'b0000_0000, 6'd0);
      bus.start = 1'b1; bus.op = 1'b1;
      tick();
      bus.start = 1'b0;
      chk_st("fresh.issue", 8'b1101_0000, 6'd0);
      tick();
      chk_st("fresh.wait", 8'b1001_0000, 6'd0);
      bus.unit_done = 1'b1;
      tick();
      bus.unit_done = 1'b0;
      chk_st("fresh.write", 8'b1001_1000, 6'd1);
      tick(); chk_st("fresh.done", 8'b1000_0100, 6'd1);
      tick(); chk_st("fresh.idle", 8'b0000_0000, 6'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 6'd40, maximum WAIT cycles before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  1  0 = multiply, 1 = divide; captured with start.
REQ-006 divisor_zero  input  1  Y operand equals zero; captured with start.
REQ-007 unit_done  input  1  completion strobe from mult/div unit.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 unit_start  output  1  one-cycle pulse launching the mult/div unit.
REQ-010 multOp  output  1  high in ISSUE, WAIT and WRITE when the captured op is 0.
REQ-011 divOp  output  1  high in ISSUE, WAIT and WRITE when the captured op is 1.
REQ-012 hilo_write  output  1  one-cycle HI/LO register write enable.
REQ-013 done  output  1  one-cycle completion pulse (normal or exception).
REQ-014 div0_exc  output  1  one-cycle divide-by-zero exception pulse.
REQ-015 timeout_exc  output  1  one-cycle watchdog exception pulse.
REQ-016 cycles  output  6  WAIT-cycle count of current/last operation.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, WRITE, DONE, EXC; encoding is free.
REQ-018 IDLE + start=1: capture op, divisor_zero; next state ISSUE, except op=1 with divisor_zero=1 -> EXC.
REQ-019 IDLE + start=0: remain IDLE; all pulse outputs 0.
REQ-020 ISSUE: unit_start=1 for exactly that cycle; cycles cleared to 0; next WAIT unconditionally.
REQ-021 WAIT: cycles increments by 1 per cycle, saturating at 63.
REQ-022 WAIT + unit_done=1 -> WRITE.
REQ-023 WAIT + unit_done=0 with cycles equal to TIMEOUT-1 -> EXC (timeout cause).
REQ-024 unit_done takes priority over timeout in the same cycle.
REQ-025 WRITE: hilo_write=1 for one cycle; next DONE.
REQ-026 DONE: done=1 for one cycle; next IDLE.
REQ-027 EXC: done=1 plus exactly one of div0_exc or timeout_exc per captured cause; hilo_write=0; next IDLE.
REQ-028 Divide-by-zero path SHALL never assert unit_start, multOp or divOp.
REQ-029 start while busy=1 SHALL be ignored: no capture, no queueing.
REQ-030 unit_done outside WAIT SHALL be ignored.
REQ-031 Latency, normal path: start at cycle 0 -> unit_start at 1; unit_done at cycle k (k>=2) -> hilo_write at k+1, done at k+2, IDLE at k+3.
REQ-032 Back-to-back: start accepted again in the IDLE cycle following DONE/EXC.
REQ-033 op and divisor_zero changes after capture SHALL have no effect on the running operation.
REQ-034 All outputs SHALL be driven from registered state; no combinational path from inputs to outputs.

Reset
REQ-035 reset=1 at a clock edge -> IDLE; busy, unit_start, multOp, divOp, hilo_write, done, div0_exc, timeout_exc = 0; cycles = 0.
REQ-036 reset in any state (including mid-WAIT) SHALL abort without hilo_write or done; reset has priority over start and unit_done.

Verification
REQ-037 start=1, op=0 at cycle 0; unit_done at cycle 5 -> unit_start@1, multOp 1..6, hilo_write@6, done@7, cycles=4, busy low @8.
REQ-038 start=1, op=1, divisor_zero=1 -> EXC next cycle: done=1, div0_exc=1, unit_start never asserted, divOp=0.
REQ-039 start=1, op=1, divisor_zero=0, unit_done never -> timeout_exc and done together once cycles reaches 39 (TIMEOUT=40); hilo_write never asserted.
REQ-040 unit_done=1 in the same cycle cycles=39 -> WRITE path taken; timeout_exc stays 0.
REQ-041 start pulsed during WAIT with op toggled -> ignored; original op output held; single done.
REQ-042 reset asserted at WAIT cycle 3 -> all outputs 0 next cycle; no done; fresh start then completes normally.
